// File: rtl/vga_halve.sv
// rtl/vga_halve.sv - VGA-to-TV line halver: keeps every other line, averages pixel pairs, replays at half rate
module vga_halve #(
  parameter int LINE_PIX = 720
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_start,
  input  logic       scanin_start,
  input  logic [5:0] pix_in,
  input  logic       tv_line_start,
  input  logic       scanout_start,
  output logic [5:0] pix_out
);

  localparam int         OUT_PIX = LINE_PIX / 2;
  localparam logic [9:0] LAST_IN = 10'(LINE_PIX - 1);
  localparam logic [8:0] LAST_RD = 9'(OUT_PIX - 1);
  localparam logic [9:0] OUT_END = 10'(OUT_PIX);

  // line parity and ping-pong page
  logic       parity;
  logic       page;
  logic       accept;

  // capture side
  logic       cap_active;
  logic [9:0] in_cnt;
  logic [5:0] hold;
  logic [8:0] wr_addr;
  logic       wr_en;
  logic [2:0] sum_r, sum_g, sum_b;
  logic [5:0] avg;

  // playout side
  logic       play_active;
  logic [8:0] rd_addr;
  logic       phase;
  logic [9:0] rd_idx;
  logic       rd_req;
  logic       rd_vld;
  logic [5:0] rd_data;

  // line buffer: two pages of up to 512 averaged pixels
  logic [5:0] mem [0:1023];

  // a coincident vsync forces parity to 0, so that line is always kept
  assign accept = vsync_start | ~parity;

  // rounding average per 2-bit channel; ties round up via the +1
  assign sum_r = {1'b0, hold[5:4]} + {1'b0, pix_in[5:4]} + 3'd1;
  assign sum_g = {1'b0, hold[3:2]} + {1'b0, pix_in[3:2]} + 3'd1;
  assign sum_b = {1'b0, hold[1:0]} + {1'b0, pix_in[1:0]} + 3'd1;
  assign avg   = {sum_r[2:1], sum_g[2:1], sum_b[2:1]};

  // the second pixel of each pair completes the average and triggers the write
  assign wr_en = cap_active & in_cnt[0];

  // read address leads rd_addr by the phase bit so the two-stage read pipe lands on time;
  // a start strobe fetches address 0 in the same cycle
  assign rd_idx = scanout_start ? 10'd0 : ({1'b0, rd_addr} + {9'd0, phase});
  assign rd_req = scanout_start | (play_active & (rd_idx < OUT_END));

  // page swaps once per TV line; writes and reads see the pre-toggle value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page <= 1'b0;
    end else if (tv_line_start) begin
      page <= ~page;
    end
  end

  // capture control: parity tracking, pixel counting and pair holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity     <= 1'b0;
      cap_active <= 1'b0;
      in_cnt     <= '0;
      hold       <= '0;
      wr_addr    <= '0;
    end else begin
      if (cap_active) begin
        in_cnt <= in_cnt + 10'd1;
        if (!in_cnt[0]) begin
          hold <= pix_in;
        end else begin
          wr_addr <= wr_addr + 9'd1;
        end
        if (in_cnt == LAST_IN) begin
          cap_active <= 1'b0;
        end
      end
      if (scanin_start) begin
        // a rejected line also aborts any capture still running
        parity <= accept;
        if (accept) begin
          cap_active <= 1'b1;
          in_cnt     <= '0;
          wr_addr    <= '0;
        end else begin
          cap_active <= 1'b0;
        end
      end else if (vsync_start) begin
        parity <= 1'b0;
      end
    end
  end

  // buffer write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{page, wr_addr}] <= avg;
    end
  end

  // buffer read port, registered
  always_ff @(posedge clk) begin
    rd_data <= mem[{~page, rd_idx[8:0]}];
  end

  // playout counter: one buffer entry per two clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_active <= 1'b0;
      rd_addr     <= '0;
      phase       <= 1'b0;
    end else if (scanout_start) begin
      play_active <= 1'b1;
      rd_addr     <= '0;
      phase       <= 1'b0;
    end else if (play_active) begin
      phase <= ~phase;
      if (phase) begin
        if (rd_addr == LAST_RD) begin
          play_active <= 1'b0;
        end else begin
          rd_addr <= rd_addr + 9'd1;
        end
      end
    end
  end

  // output stage: blank whenever the read issued two clocks ago was not part of a playout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      pix_out <= '0;
    end else begin
      rd_vld  <= rd_req;
      pix_out <= rd_vld ? rd_data : 6'd0;
    end
  end

endmodule

// File: tb/tb_vga_halve.sv
// tb/tb_vga_halve.sv - randomized scoreboard bench for vga_halve
module tb_vga_halve;

  localparam int LINE_PIX = 720;
  localparam int OUT_PIX  = LINE_PIX / 2;
  localparam int LINE_LEN = 800;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync_start = 1'b0;
  logic       scanin_start = 1'b0;
  logic [5:0] pix_in = '0;
  logic       tv_line_start = 1'b0;
  logic       scanout_start = 1'b0;
  logic [5:0] pix_out;

  vga_halve #(.LINE_PIX(LINE_PIX)) dut (
    .clk(clk), .rst_n(rst_n), .vsync_start(vsync_start), .scanin_start(scanin_start),
    .pix_in(pix_in), .tv_line_start(tv_line_start), .scanout_start(scanout_start),
    .pix_out(pix_out)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [5:0] v; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit in_rst = 1'b1;

  // reference model state
  logic [5:0] mbuf [2][512];
  bit         mknown [2][512];
  logic [5:0] lpx [LINE_PIX];
  int m_page, m_par, m_cap, m_S, m_play, m_T;

  function automatic logic [5:0] avg2(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r;
    int s;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = int'((a >> (2 * ch)) & 6'd3) + int'((b >> (2 * ch)) & 6'd3) + 1;
      r = r | (6'(s / 2) << (2 * ch));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_page = 0; m_par = 0; m_cap = 0; m_S = 0; m_play = 0; m_T = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 512; i++) mknown[p][i] = 1'b0;
  endtask

  // monitor: compares every expectation due in the current cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
          exp_t e;
          e = q.pop_front();
          check("pix_out", pix_out, e.v);
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // one clock of stimulus plus the model's view of it
  task automatic step(input bit vs, input bit si, input bit tl, input bit so, input logic [5:0] px);
    int a, k, eff;
    vsync_start = vs; scanin_start = si; tv_line_start = tl; scanout_start = so; pix_in = px;
    // output two clocks from now follows from the playout start time
    if (so) begin m_play = 1; m_T = cyc; end
    if (m_play != 0 && (cyc - m_T) < 2 * OUT_PIX) begin
      a = (cyc - m_T) / 2;
      if (mknown[1 - m_page][a]) q.push_back('{cyc + 2, mbuf[1 - m_page][a]});
    end else begin
      q.push_back('{cyc + 2, 6'd0});
    end
    // capture: pixel k arrives k+1 clocks after the accepted start
    if (m_cap != 0) begin
      k = cyc - m_S - 1;
      lpx[k] = px;
      if (k % 2 == 1) begin
        mbuf[m_page][k / 2] = avg2(lpx[k - 1], px);
        mknown[m_page][k / 2] = 1'b1;
      end
      if (k == LINE_PIX - 1) m_cap = 0;
    end
    if (si) begin
      eff = vs ? 0 : m_par;
      m_par = (eff == 0) ? 1 : 0;
      if (eff == 0) begin m_cap = 1; m_S = cyc; end
      else m_cap = 0;
    end else if (vs) begin
      m_par = 0;
    end
    if (tl) m_page = 1 - m_page;
    adv();
    vsync_start = 1'b0; scanin_start = 1'b0; tv_line_start = 1'b0; scanout_start = 1'b0;
  endtask

  // one VGA line; strobe positions are line-relative, -1 means absent
  // mode 0: a/b pairs; mode 1: random; mode 2: random until si2, then a/b pairs
  task automatic vline(input int vs_at, input int si_at, input int si2_at, input int tl_at,
                       input int so_at, input int so2_at, input int mode,
                       input logic [5:0] a, input logic [5:0] b);
    int lsi;
    int idx;
    logic [5:0] px;
    lsi = -1000;
    for (int j = 0; j < LINE_LEN; j++) begin
      idx = j - lsi - 1;
      if (mode == 1 || idx < 0 || (mode == 2 && j <= si2_at)) px = 6'($urandom);
      else px = (idx % 2 == 0) ? a : b;
      step(j == vs_at, (j == si_at) || (j == si2_at), j == tl_at,
           (j == so_at) || (j == so2_at), px);
      if (j == si_at || j == si2_at) lsi = j;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 6'($urandom));
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    model_reset();
    q.delete();
    q.push_back('{cyc, 6'd0});
    q.push_back('{cyc + 1, 6'd0});
    in_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pix_out", pix_out, 6'd0);
    release_reset();
    idle(4);

    // reset mid-playout with page toggled to 1
    step(1'b0, 1'b0, 1'b1, 1'b1, 6'd0);
    idle(100);
    #2;
    rst_n = 1'b0;
    in_rst = 1'b1;
    q.delete();
    #1;
    check("async_reset_pix_out", pix_out, 6'd0);
    check("reset_page", {5'd0, dut.page}, 6'd0);
    repeat (3) @(posedge clk);
    #1;
    cyc += 3;
    release_reset();
    idle(20);

    // 00/3F pairs average to 2A on every channel
    vline(0, 1, -1, -1, -1, -1, 0, 6'h00, 6'h3F);
    vline(-1, 1, -1, 0, 3, -1, 1, 6'h00, 6'h00);

    // rounding pair
    vline(-1, 1, -1, -1, -1, -1, 0, 6'b01_10_11, 6'b10_10_00);
    vline(-1, 1, -1, 0, 3, -1, 1, 6'h00, 6'h00);

    // parity ramp: only lines 0 and 2 of the frame are kept
    vline(0, 1, -1, -1, -1, -1, 0, 6'h00, 6'h00);
    vline(-1, 1, -1, 0, 3, -1, 0, 6'h02, 6'h02);
    vline(-1, 1, -1, -1, -1, -1, 0, 6'h04, 6'h04);
    vline(-1, 1, -1, 0, 3, -1, 0, 6'h06, 6'h06);

    // dropped line must not disturb the kept one in the same page
    vline(0, 1, -1, -1, -1, -1, 0, 6'h11, 6'h11);
    vline(-1, 1, -1, -1, -1, -1, 0, 6'h22, 6'h22);
    vline(-1, -1, -1, 0, 3, -1, 1, 6'h00, 6'h00);

    // capture restart (vsync keeps it accepted) and playout restart
    vline(101, 1, 101, -1, -1, -1, 2, 6'h15, 6'h15);
    vline(-1, 1, -1, 0, 3, 203, 1, 6'h00, 6'h00);

    // page swap coincident with the final pair write
    vline(-1, 1, -1, 721, -1, -1, 1, 6'h00, 6'h00);
    vline(-1, 1, -1, -1, 3, -1, 1, 6'h00, 6'h00);

    // random frames
    for (int n = 0; n < 2; n++) begin
      vline(0, 1, -1, -1, -1, -1, 1, 6'h00, 6'h00);
      vline(-1, 1, -1, 0, 3, -1, 1, 6'h00, 6'h00);
    end

    idle(10);
    total++;
    if (q.size() > 2) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required<=2", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
